// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding and constant helpers for overflow limit and counter sizing.
package bin2bcd_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 32'd1;
    for (int unsigned i = 32'd0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Add-3 correction so the following left shift carries into the next digit
  always_comb begin
    if (digit >= 4'd5) begin
      corrected = digit + 4'd3;
    end else begin
      corrected = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with start/busy/done handshake and held, registered results.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     BLANK,
  output logic                  OVF
);

  localparam int          ACC_W     = 4 * (DIGITS + 1);
  localparam int          CNT_W     = int'(clog2(32'(WIDTH)));
  localparam int unsigned LIMIT     = pow10(32'(DIGITS)) - 32'd1;
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  logic [0:0]            state_r;
  logic [ACC_W-1:0]      acc_r;
  logic [WIDTH-1:0]      sh_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  pend_ovf_r;
  logic                  busy_r;
  logic                  done_r;
  logic [4*DIGITS-1:0]   bcd_r;
  logic [DIGITS-1:0]     blank_r;
  logic                  ovf_r;

  logic [ACC_W-1:0]      corr_s;
  logic [ACC_W-1:0]      acc_next_s;
  logic [WIDTH-1:0]      sh_next_s;
  logic [4*DIGITS-1:0]   res_bcd_s;
  logic [DIGITS-1:0]     res_blank_s;
  logic                  ovf_cmp_s;
  logic                  last_s;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (acc_r[4*g +: 4]),
      .corrected (corr_s[4*g +: 4])
    );
  end

  // Accumulator and shift register move left together as one register
  assign acc_next_s = {corr_s[ACC_W-2:0], sh_r[WIDTH-1]};
  assign sh_next_s  = {sh_r[WIDTH-2:0], 1'b0};
  assign ovf_cmp_s  = (32'(BIN) > LIMIT);
  assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));

  // Final result: saturate to all nines on overflow, else derive leading-zero mask
  always_comb begin
    logic nz;
    nz          = 1'b0;
    res_bcd_s   = acc_next_s[4*DIGITS-1:0];
    res_blank_s = {DIGITS{1'b0}};
    if (pend_ovf_r) begin
      res_bcd_s = {DIGITS{4'd9}};
    end else begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        nz             = nz | (res_bcd_s[4*i +: 4] != 4'd0);
        res_blank_s[i] = ~nz;
      end
    end
  end

  // FSM, datapath and held output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      acc_r      <= {ACC_W{1'b0}};
      sh_r       <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      pend_ovf_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= {(4*DIGITS){1'b0}};
      blank_r    <= BLANK_RST;
      ovf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            sh_r       <= BIN;
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            pend_ovf_r <= ovf_cmp_s;
            busy_r     <= 1'b1;
            state_r    <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc_r <= acc_next_s;
          sh_r  <= sh_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            bcd_r   <= res_bcd_s;
            blank_r <= res_blank_s;
            ovf_r   <= pend_ovf_r;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign BCD   = bcd_r;
  assign BLANK = blank_r;
  assign OVF   = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: two converters (3 and 2 digits) against a divide/modulo
// reference model, covering handshake, back-to-back, reset and exhaustive inputs.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [2:0]  blank_a;
  logic [1:0]  blank_b;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .BIN(bin_a),
    .BUSY(busy_a), .DONE(done_a), .BCD(bcd_a), .BLANK(blank_a), .OVF(ovf_a)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .BIN(bin_b),
    .BUSY(busy_b), .DONE(done_b), .BCD(bcd_b), .BLANK(blank_b), .OVF(ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] last_bcd   [2];
  logic [4:0]  last_blank [2];
  logic        last_ovf   [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, blank when value has fewer digits
  function automatic void model(input int d, input int v,
                                output logic [19:0] b, output logic [4:0] bl, output logic o);
    int p;
    int lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    b  = 20'd0;
    bl = 5'd0;
    o  = (v > lim - 1);
    p  = 1;
    for (int i = 0; i < d; i++) begin
      if (o) begin
        b[4*i +: 4] = 4'd9;
      end else begin
        b[4*i +: 4] = 4'((v / p) % 10);
        if (i >= 1) bl[i] = (v < p);
      end
      p = p * 10;
    end
  endfunction

  function automatic logic [19:0] cur_bcd(input int sel);
    return (sel == 1) ? {12'd0, bcd_b} : {8'd0, bcd_a};
  endfunction
  function automatic logic [4:0] cur_blank(input int sel);
    return (sel == 1) ? {3'd0, blank_b} : {2'd0, blank_a};
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 1) ? done_b : done_a;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 1) ? busy_b : busy_a;
  endfunction
  function automatic logic cur_ovf(input int sel);
    return (sel == 1) ? ovf_b : ovf_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] v);
    if (sel == 1) begin
      start_b = s;
      bin_b   = v;
    end else begin
      start_a = s;
      bin_a   = v;
    end
  endtask

  task automatic set_reset_last();
    last_bcd[0] = 20'd0;  last_blank[0] = 5'b00110; last_ovf[0] = 1'b0;
    last_bcd[1] = 20'd0;  last_blank[1] = 5'b00010; last_ovf[1] = 1'b0;
  endtask

  // One conversion with scrambled BIN during CONV and hold checks until DONE
  task automatic convert(input int sel, input int v);
    int          n;
    logic        ok;
    logic [19:0] eb;
    logic [4:0]  ebl;
    logic        eo;
    model((sel == 1) ? 2 : 3, v, eb, ebl, eo);
    drive(sel, 1'b1, 8'(v));
    tick();
    check_val("done_pulse", 32'(cur_done(sel)), 32'd0);
    check_val("busy_set", 32'(cur_busy(sel)), 32'd1);
    n  = 0;
    ok = 1'b1;
    do begin
      ok = ok & (cur_bcd(sel) == last_bcd[sel]) & (cur_blank(sel) == last_blank[sel])
              & (cur_ovf(sel) == last_ovf[sel]);
      drive(sel, 1'b0, 8'($urandom_range(0, 255)));
      tick();
      n++;
    end while (!cur_done(sel) && n < 30);
    check_val("hold", 32'(ok), 32'd1);
    check_val("latency", n, 32'd8);
    check_val("busy_clr", 32'(cur_busy(sel)), 32'd0);
    check_val("bcd", 32'(cur_bcd(sel)), 32'(eb));
    check_val("blank", 32'(cur_blank(sel)), 32'(ebl));
    check_val("ovf", 32'(cur_ovf(sel)), 32'(eo));
    last_bcd[sel]   = eb;
    last_blank[sel] = ebl;
    last_ovf[sel]   = eo;
  endtask

  initial begin
    int          n;
    int          dones;
    logic [19:0] eb;
    logic [4:0]  ebl;
    logic        eo;

    rst = 1'b1;
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_done", 32'(done_a), 32'd0);
    check_val("rst_bcd", 32'(bcd_a), 32'd0);
    check_val("rst_blank", 32'(blank_a), 32'b110);
    check_val("rst_ovf", 32'(ovf_a), 32'd0);
    check_val("rst_blank_b", 32'(blank_b), 32'b10);
    set_reset_last();

    convert(0, 59);
    convert(0, 0);
    convert(0, 255);

    // START pulse mid-conversion must be ignored
    drive(0, 1'b1, 8'd123);
    tick();
    drive(0, 1'b0, 8'd0);
    tick();
    tick();
    drive(0, 1'b1, 8'd7);
    tick();
    drive(0, 1'b0, 8'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a) begin
        dones++;
        check_val("ign_bcd", 32'(bcd_a), 32'h123);
      end
    end
    check_val("ign_dones", dones, 32'd1);
    model(3, 123, last_bcd[0], last_blank[0], last_ovf[0]);

    // Back-to-back with START held high
    drive(0, 1'b1, 8'd0);
    tick();
    for (int i = 0; i < 60; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done_a && n < 30);
      check_val("b2b_gap", n, (i == 0) ? 32'd8 : 32'd9);
      model(3, i, eb, ebl, eo);
      check_val("b2b_bcd", 32'(bcd_a), 32'(eb));
      check_val("b2b_blank", 32'(blank_a), 32'(ebl));
      if (i < 59) drive(0, 1'b1, 8'(i + 1));
      else        drive(0, 1'b0, 8'd0);
    end
    model(3, 59, last_bcd[0], last_blank[0], last_ovf[0]);

    // Reset in the middle of a conversion
    convert(0, 42);
    drive(0, 1'b1, 8'd200);
    tick();
    drive(0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_bcd", 32'(bcd_a), 32'd0);
    check_val("mid_busy", 32'(busy_a), 32'd0);
    check_val("mid_blank", 32'(blank_a), 32'b110);
    check_val("mid_done", 32'(done_a), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_a) dones++;
      tick();
    end
    check_val("mid_nodone", dones, 32'd0);
    set_reset_last();
    convert(0, 77);

    for (int v = 0; v < 256; v++) convert(0, v);
    for (int i = 0; i < 20; i++) convert(0, int'($urandom_range(0, 255)));

    convert(1, 100);
    convert(1, 60);
    convert(1, 99);
    convert(1, 5);
    for (int i = 0; i < 30; i++) convert(1, int'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter. It runs a shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between a binary counter (for example the seconds/minutes counters) and the TM1638 display driver, and turns a binary count into per-digit 4-bit codes for the seven-segment inputs. A start/busy/done handshake lets the producer request a conversion only when its value changes. The last result is held stable for the display between conversions.

## Interface

Parameters:
- WIDTH, 8: binary input width; legal range 4..16.
- DIGITS, 3: number of BCD digits produced; legal range 1..5.

Ports:
- CLK  input  1: system clock; all logic is on the rising edge.
- RST  input  1: synchronous, active-high reset.
- START  input  1: conversion request; sampled only in IDLE.
- BIN  input  WIDTH: binary value; captured on the cycle START is accepted.
- BUSY  output  1: conversion in progress.
- DONE  output  1: one-cycle pulse when BCD/OVF/BLANK update.
- BCD  output  4*DIGITS: packed result; digit 0 (units) is in bits [3:0].
- BLANK  output  DIGITS: per-digit leading-zero mask; bit i=1 means digit i is a leading zero. Digit 0 is never blanked.
- OVF  output  1: the last accepted BIN exceeded 10^DIGITS−1.

## Operation

- States: IDLE and CONV.
- **Accept (IDLE, START=1):**
  - Capture BIN into a shift register.
  - Clear the internal BCD accumulator, which is DIGITS+1 digits wide so no bit is lost.
  - Set the bit counter to 0, BUSY=1, and go to CONV.
  - Latch the overflow compare (BIN > 10^DIGITS−1) into a pending flag.
- **CONV, each cycle:**
  - Every accumulator digit ≥5 gets +3.
  - Then {accumulator, shift register} shifts left 1 as one register.
  - The bit counter increments.
- **Last cycle (bit counter = WIDTH−1):**
  - Do the final iteration.
  - Load BCD from the corrected, shifted accumulator.
  - Compute BLANK from the new BCD value.
  - Load OVF from the pending flag.
  - Pulse DONE=1, set BUSY=0, return to IDLE.
- **Overflow result:** when OVF=1, BCD is forced to all 9s and BLANK to all 0s.
- **START while BUSY=1:** ignored, not queued. BIN changes during CONV have no effect.
- **START held high in IDLE:** back-to-back conversions. A new accept can happen on the cycle right after DONE.
- **Holding outputs:** BCD, BLANK and OVF change only on the DONE cycle or on reset.
- **BLANK rule:** bit i (i≥1) = 1 iff digit i and every higher digit are 0.
- **Reset values:** state=IDLE, BUSY=0, DONE=0, BCD=0, BLANK={DIGITS-1{1},0}, OVF=0, all internal registers 0.
- **Reset mid-conversion:** the conversion is abandoned, no DONE is produced, and all outputs take their reset values on the reset edge.

## Timing

- Edge k: START is accepted in IDLE. BUSY=1 from after edge k.
- Edges k+1 .. k+WIDTH: one iteration each.
- After edge k+WIDTH: DONE=1 and the new BCD is valid. BUSY=0 in the same cycle.
- Latency from the accepting edge to valid output is WIDTH cycles. Throughput is one conversion per WIDTH+1 cycles with START held high.
- DONE is high for exactly one cycle per accepted START.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `bin2bcd_pkg`, containing:
  - the state encoding (IDLE=0, CONV=1);
  - a constant function `pow10(n)` for the overflow limit;
  - a function `clog2` for the bit-counter width.
- Sub-module `bcd_add3`: a 4-bit combinational correction cell (in ≥5 → in+3, else in). It is instantiated DIGITS+1 times through generate.
- The top file holds the FSM, the shift register, the counter and the output registers.

## Test plan

- **Single value:** WIDTH=8, DIGITS=3, BIN=59, START pulse → DONE 8 cycles later, BCD=0x059, BLANK=3'b100, OVF=0.
- **Boundaries:**
  - BIN=0 → BCD=0x000, BLANK=3'b110.
  - BIN=255 → BCD=0x255, BLANK=3'b000.
- **Overflow:** DIGITS=2, BIN=100 → OVF=1, BCD=0x99, BLANK=2'b00.
  - Then BIN=60 → OVF=0, BCD=0x60.
- **Handshake:**
  - A START pulse at cycle 3 of CONV is ignored: exactly one DONE, with the first value.
  - START held high with BIN stepping 0..59 → 60 DONE pulses, each 9 cycles apart, all results correct.
- **Reset mid-conversion:** RST asserted at cycle 4 of CONV with prior BCD=0x042 → no DONE, BCD=0, BUSY=0, BLANK=3'b110 after the edge.
  - The next START converts normally.
- **Exhaustive check:** all BIN 0..255 against a reference model, checking DONE-cycle alignment and that outputs are stable between DONE pulses.
